// File: rtl/mem_wb_stage_if.sv
// EXE -> MEM/WB instruction bus.
// Handshake: EXE presents an instruction with exe_valid=1; the receiver takes it
// on any rising edge where exe_valid=1 and stall=0. While stall=1, EXE must hold
// every bus field unchanged. There is no separate ready signal: !stall is the ready.
interface mem_wb_stage_if;
    logic        exe_valid;
    logic [31:0] exe_out;
    logic        z_flag;
    logic [31:0] pc_in;
    logic        is_computational;
    logic        is_load_store;
    logic        is_load;
    logic        is_branch;
    logic [3:0]  rd;
    logic [31:0] store_data;
    logic        stall;

    // EXE side
    modport master (
        output exe_valid, exe_out, z_flag, pc_in, is_computational,
               is_load_store, is_load, is_branch, rd, store_data,
        input  stall
    );

    // MEM/WB side
    modport slave (
        input  exe_valid, exe_out, z_flag, pc_in, is_computational,
               is_load_store, is_load, is_branch, rd, store_data,
        output stall
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: accepts EXE results, performs the data-memory access over a
// req/ack handshake, drives the register-file write port and PC redirect, and
// reports one retirement pulse per instruction.
// Optional feature macro: MEM_TIMEOUT_EN (abort a memory access that is not
// acknowledged within TIMEOUT_CYCLES cycles and set the sticky mem_err flag).
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_wb_stage_if.slave        exe,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 rf_we,
    output logic [3:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 pc_redirect,
    output logic [31:0]          pc_target,
    output logic                 retire_valid,
    output logic [31:0]          retire_pc,
    output logic                 mem_err,
    output logic                 dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_mem_done;
    logic        w_timeout;

    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic        r_dmem_we;
    logic [3:0]  r_rd;
    logic [31:0] r_pc;
    logic        r_is_load;

    logic        r_rf_we;
    logic [3:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_pc_redirect;
    logic [31:0] r_pc_target;
    logic        r_retire_valid;
    logic [31:0] r_retire_pc;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wait_cnt;
    logic          r_mem_err;

    // The abort fires on the edge that would bring the no-ack count to the limit;
    // an ack in that same cycle takes precedence in the next-state logic.
    assign w_timeout = (r_state == S_MEM) && !dmem_ack &&
                       (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter cleared on MEM entry; sticky error set on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (w_accept && exe.is_load_store) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_MEM && !dmem_ack) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Next-state logic: accept only in IDLE, leave MEM on ack or abort.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mem_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (exe.exe_valid) begin
                    w_accept = 1'b1;
                    if (exe.is_load_store) begin
                        w_state_next = S_MEM;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ack || w_timeout) begin
                    w_mem_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register plus latched request and writeback/retire outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_we      <= 1'b0;
            r_rd           <= '0;
            r_pc           <= '0;
            r_is_load      <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_pc_redirect  <= 1'b0;
            r_pc_target    <= '0;
            r_retire_valid <= 1'b0;
            r_retire_pc    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_rf_we        <= 1'b0;
            r_pc_redirect  <= 1'b0;
            r_retire_valid <= 1'b0;

            if (w_accept) begin
                if (exe.is_load_store) begin
                    r_dmem_addr  <= exe.exe_out;
                    r_dmem_wdata <= exe.store_data;
                    r_dmem_we    <= !exe.is_load;
                    r_rd         <= exe.rd;
                    r_pc         <= exe.pc_in;
                    r_is_load    <= exe.is_load;
                end else if (exe.is_branch) begin
                    r_pc_redirect  <= exe.z_flag;
                    r_pc_target    <= exe.exe_out;
                    r_retire_valid <= 1'b1;
                    r_retire_pc    <= exe.pc_in;
                end else if (exe.is_computational) begin
                    r_rf_we        <= (exe.rd != 4'd0);
                    r_rf_waddr     <= exe.rd;
                    r_rf_wdata     <= exe.exe_out;
                    r_retire_valid <= 1'b1;
                    r_retire_pc    <= exe.pc_in;
                end
            end

            if (w_mem_done) begin
                r_retire_valid <= 1'b1;
                r_retire_pc    <= r_pc;
                // A timed-out load retires without writing the register file.
                if (dmem_ack && r_is_load) begin
                    r_rf_we    <= (r_rd != 4'd0);
                    r_rf_waddr <= r_rd;
                    r_rf_wdata <= dmem_rdata;
                end
            end
        end
    end

    assign exe.stall    = (r_state == S_MEM);
    assign dmem_req     = (r_state == S_MEM);
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign pc_redirect  = r_pc_redirect;
    assign pc_target    = r_pc_target;
    assign retire_valid = r_retire_valid;
    assign retire_pc    = r_retire_pc;
    assign dbg_state    = r_state;

endmodule
